fuel_sum_unit: RTL

Sequential fuel accumulator for the Day 1 NoMem datapath; sits directly downstream of the 1-bit subtraction adder chains. It accepts module masses one at a time over a valid/ready handshake and computes fuel = floor(mass/3) − 2 with a bit-serial divide-by-3. Results at or below zero clamp to 0. Fuel values are summed into a running total, which is presented once the last mass of a batch has been processed.

---
 rtl/fuel_sum_unit.sv | 128 ++++++++++++
 1 files changed

// File: rtl/fuel_sum_unit.sv
// Bit-serial fuel accumulator: fuel = max(floor(mass/3) - 2, 0), summed per batch.
// Define FUEL_SUM_RECURSIVE_EN to feed each nonzero fuel back as a new mass (Part 2 mode).
module fuel_sum_unit #(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned SUM_WIDTH = 48
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     Mass_In,
  input  logic                 Mass_Valid,
  input  logic                 Last,
  output logic                 Mass_Ready,
  output logic [SUM_WIDTH-1:0] Sum_Out,
  output logic                 Sum_Valid,
  output logic                 Busy
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [2:0] {StIdle, StDiv, StSub, StAcc, StDone} state_e;

  state_e               state_q, state_d;
  logic [WIDTH-1:0]     dividend_q, quot_q, fuel_q;
  logic [1:0]           rem_q;
  logic [CntW-1:0]      cnt_q;
  logic                 last_q;
  logic [SUM_WIDTH-1:0] sum_q;

  logic                       accept;
  logic [2:0]                 trial;
  logic                       q_bit;
  logic [1:0]                 rem_next;
  logic                       div_last;
  logic                       again;
  logic [SUM_WIDTH+WIDTH-1:0] fuel_wide;
  logic [SUM_WIDTH-1:0]       fuel_ext;

  assign accept   = Mass_Valid && Mass_Ready;
  // Restoring divide-by-3 step: remainder shifted left with the next dividend bit.
  assign trial    = {rem_q, dividend_q[WIDTH-1]};
  assign q_bit    = (trial >= 3'd3);
  assign rem_next = q_bit ? 2'(trial - 3'd3) : trial[1:0];
  assign div_last = (cnt_q == CntW'(WIDTH - 1));
  // Zero-extend or truncate fuel to the accumulator width.
  assign fuel_wide = {{SUM_WIDTH{1'b0}}, fuel_q};
  assign fuel_ext  = fuel_wide[SUM_WIDTH-1:0];

`ifdef FUEL_SUM_RECURSIVE_EN
  assign again = (fuel_q != '0);
`else
  assign again = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: if (accept) state_d = StDiv;
      StDiv:          if (div_last) state_d = StSub;
      StSub:          state_d = StAcc;
      StAcc: begin
        if (again)       state_d = StDiv;
        else if (last_q) state_d = StDone;
        else             state_d = StIdle;
      end
      default:        state_d = StIdle;
    endcase
  end

  always_comb begin
    Mass_Ready = (state_q == StIdle) || (state_q == StDone);
    Busy       = !Mass_Ready;
    Sum_Valid  = (state_q == StDone);
    Sum_Out    = sum_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dividend_q <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      cnt_q      <= '0;
      last_q     <= 1'b0;
      fuel_q     <= '0;
      sum_q      <= '0;
    end else begin
      case (state_q)
        StIdle, StDone: begin
          if (accept) begin
            dividend_q <= Mass_In;
            last_q     <= Last;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
            if (state_q == StDone) sum_q <= '0;
          end
        end
        StDiv: begin
          dividend_q <= {dividend_q[WIDTH-2:0], 1'b0};
          quot_q     <= {quot_q[WIDTH-2:0], q_bit};
          rem_q      <= rem_next;
          cnt_q      <= cnt_q + CntW'(1);
        end
        StSub: begin
          fuel_q <= (quot_q >= WIDTH'(3)) ? quot_q - WIDTH'(2) : '0;
        end
        StAcc: begin
          sum_q <= sum_q + fuel_ext;
          if (again) begin
            dividend_q <= fuel_q;
            quot_q     <= '0;
            rem_q      <= '0;
            cnt_q      <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
